// File: rtl/mouse_packet_decoder_if.sv
// mouse_packet_decoder_if: byte stream from the PS/2 receiver into the packet decoder
//   rx_data  : received PS/2 byte
//   rx_valid : one-cycle strobe, rx_data valid this cycle
interface mouse_packet_decoder_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   modport master (output rx_data, rx_valid);
   modport slave  (input rx_data, rx_valid);
endinterface

// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder: assembles 3-byte PS/2 mouse packets into a clamped cursor, board grid cell and click outputs
//   clk, rst (async, active-high), interboard_rst (sync re-centre)
//   rx             : byte stream (rx_data, rx_valid) from the PS/2 receiver
//   packet_done    : pulse while a packet is applied
//   mouse_x/y      : cursor position, clamped to the screen
//   l_click        : pulse on left-button press edge
//   cheat_activate : right button held in the last packet
//   mouse_valid, mouse_block_x/y : grid cell under the cursor, one cycle behind the position
//   Optional: define MOUSE_ACCEL_EN to double deltas of magnitude 16 or more.
module mouse_packet_decoder #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BOARD_X0    = 0,
   parameter int BOARD_Y0    = 0,
   parameter int BLOCK_W     = 32,
   parameter int BLOCK_H     = 60,
   parameter int COLS        = 20,
   parameter int ROWS        = 8,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  interboard_rst,
   mouse_packet_decoder_if.slave rx,
   output logic                  packet_done,
   output logic [9:0]            mouse_x,
   output logic [8:0]            mouse_y,
   output logic                  l_click,
   output logic                  cheat_activate,
   output logic                  mouse_valid,
   output logic [4:0]            mouse_block_x,
   output logic [2:0]            mouse_block_y
);
   typedef enum logic [1:0] {B0, B1, B2, UPD} state_t;
   localparam int CW = $clog2(TIMEOUT_CYC);
   // Division by a constant is done as a compare ladder against multiples of the block size.
   function automatic logic [8:0] grid(input logic [9:0] x, input logic [8:0] y);
      int xo, yo;
      logic [4:0] bx;
      logic [2:0] by;
      logic v;
      xo = int'(x) - BOARD_X0;
      yo = int'(y) - BOARD_Y0;
      v = xo >= 0 && xo < COLS * BLOCK_W && yo >= 0 && yo < ROWS * BLOCK_H;
      bx = '0;
      by = '0;
      for (int i = 1; i < COLS; i++) if (xo >= i * BLOCK_W) bx = 5'(i);
      for (int i = 1; i < ROWS; i++) if (yo >= i * BLOCK_H) by = 3'(i);
      return v ? {v, bx, by} : 9'd0;
   endfunction
   function automatic logic signed [11:0] eff(input logic sgn, input logic [7:0] b, input logic ovf);
      logic signed [11:0] d;
      d = {{4{sgn}}, b};
`ifdef MOUSE_ACCEL_EN
      if (d >= 12'sd16 || d <= -12'sd16) d = d <<< 1;
`endif
      return ovf ? 12'sd0 : d;
   endfunction
   function automatic logic [9:0] clampv(input logic signed [11:0] v, input int maxv);
      return v < 0 ? 10'd0 : (int'(v) > maxv ? 10'(maxv) : v[9:0]);
   endfunction
   localparam logic [9:0] X_RST = 10'(SCREEN_W / 2);
   localparam logic [8:0] Y_RST = 9'(SCREEN_H / 2);
   localparam logic [8:0] GRID_RST = grid(X_RST, Y_RST);
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [5:0]        b0_q, b0_d;     // {y_ovf, x_ovf, y_sign, x_sign, R, L}
   logic [7:0]        dx_q, dx_d, dy_q, dy_d;
   logic              prev_l_q, prev_l_d, cheat_q, cheat_d;
   logic [9:0]        x_q, x_d;
   logic [8:0]        y_q, y_d, grid_q, grid_d;
   logic signed [11:0] nx, ny;
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      b0_d     = b0_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      prev_l_d = prev_l_q;
      cheat_d  = cheat_q;
      x_d      = x_q;
      y_d      = y_q;
      nx       = $signed({2'b00, x_q}) + eff(b0_q[2], dx_q, b0_q[4]);
      ny       = $signed({3'b000, y_q}) - eff(b0_q[3], dy_q, b0_q[5]);
      grid_d   = grid(x_q, y_q);
      case (state_q)
         B0: if (rx.rx_valid && rx.rx_data[3]) begin
            b0_d    = {rx.rx_data[7:4], rx.rx_data[1:0]};
            state_d = B1;
         end
         B1: if (rx.rx_valid) begin
            dx_d    = rx.rx_data;
            state_d = B2;
         end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) state_d = B0;
         else cnt_d = cnt_q + 1'b1;
         B2: if (rx.rx_valid) begin
            dy_d    = rx.rx_data;
            state_d = UPD;
         end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) state_d = B0;
         else cnt_d = cnt_q + 1'b1;
         UPD: begin
            state_d  = B0;
            x_d      = clampv(nx, SCREEN_W - 1);
            y_d      = 9'(clampv(ny, SCREEN_H - 1));
            cheat_d  = b0_q[1];
            prev_l_d = b0_q[0];
         end
      endcase
      if (interboard_rst) begin
         state_d  = B0;
         cnt_d    = '0;
         x_d      = X_RST;
         y_d      = Y_RST;
         cheat_d  = 1'b0;
         prev_l_d = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= B0;
         cnt_q    <= '0;
         b0_q     <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         prev_l_q <= 1'b0;
         cheat_q  <= 1'b0;
         x_q      <= X_RST;
         y_q      <= Y_RST;
         grid_q   <= GRID_RST;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         b0_q     <= b0_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         prev_l_q <= prev_l_d;
         cheat_q  <= cheat_d;
         x_q      <= x_d;
         y_q      <= y_d;
         grid_q   <= grid_d;
      end
   end
   // A re-centre request in the update cycle wins, so the packet is neither applied nor reported.
   assign packet_done    = state_q == UPD && !interboard_rst;
   assign l_click        = packet_done && b0_q[0] && !prev_l_q;
   assign cheat_activate = cheat_q;
   assign mouse_x        = x_q;
   assign mouse_y        = y_q;
   assign mouse_valid    = grid_q[8];
   assign mouse_block_x  = grid_q[7:3];
   assign mouse_block_y  = grid_q[2:0];
endmodule

// File: tb/tb_mouse_packet_decoder.sv
// tb_mouse_packet_decoder: directed packets with a scoreboard of hand-computed cursor/grid/button results
module tb_mouse_packet_decoder;
   localparam int TO = 20;
   logic clk = 1'b0, rst = 1'b1, interboard_rst = 1'b0;
   logic packet_done, l_click, cheat_activate, mouse_valid;
   logic [9:0] mouse_x;
   logic [8:0] mouse_y;
   logic [4:0] mouse_block_x;
   logic [2:0] mouse_block_y;
   mouse_packet_decoder_if rxi ();
   mouse_packet_decoder #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .rx(rxi.slave),
      .packet_done(packet_done), .mouse_x(mouse_x), .mouse_y(mouse_y),
      .l_click(l_click), .cheat_activate(cheat_activate), .mouse_valid(mouse_valid),
      .mouse_block_x(mouse_block_x), .mouse_block_y(mouse_block_y));
   always #5 clk = ~clk;
   typedef struct {
      logic l;
      int x, y;
      logic ch;
      int bx, by;
   } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, pushed = 0, seen = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rxi.rx_data = b;
      rxi.rx_valid = 1'b1;
      @(posedge clk); #1;
      rxi.rx_valid = 1'b0;
   endtask
   task automatic send_pkt(input logic [7:0] b0, b1, b2, input logic l, input int x, y,
                           input logic ch, input int bx, by);
      q.push_back('{l, x, y, ch, bx, by});
      pushed++;
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      repeat (4) @(posedge clk);
   endtask
   initial begin : monitor
      exp_t e;
      @(negedge rst);
      forever begin
         @(negedge clk);
         if (packet_done) begin
            seen++;
            if (q.size() == 0) chk("unexpected_packet", 1, 0);
            else begin
               e = q.pop_front();
               chk("l_click", int'(l_click), int'(e.l));
               @(negedge clk);
               chk("packet_done_width", int'(packet_done), 0);
               chk("l_click_width", int'(l_click), 0);
               chk("mouse_x", int'(mouse_x), e.x);
               chk("mouse_y", int'(mouse_y), e.y);
               chk("cheat", int'(cheat_activate), int'(e.ch));
               @(negedge clk);
               chk("mouse_valid", int'(mouse_valid), 1);
               chk("block_x", int'(mouse_block_x), e.bx);
               chk("block_y", int'(mouse_block_y), e.by);
            end
         end
      end
   end
   initial begin
      int budget;
      rxi.rx_data = 8'h00;
      rxi.rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_x", int'(mouse_x), 320);
      chk("rst_y", int'(mouse_y), 240);
      chk("rst_done", int'(packet_done), 0);
      chk("rst_l", int'(l_click), 0);
      chk("rst_cheat", int'(cheat_activate), 0);
      chk("rst_valid", int'(mouse_valid), 1);
      chk("rst_bx", int'(mouse_block_x), 10);
      chk("rst_by", int'(mouse_block_y), 4);
      send_pkt(8'h08, 8'h0A, 8'h05, 0, 330, 235, 0, 10, 3);
      send_pkt(8'h18, 8'hF6, 8'h00, 0, 320, 235, 0, 10, 3);
      send_pkt(8'h08, 8'hFF, 8'h00, 0, 575, 235, 0, 17, 3);
      send_pkt(8'h08, 8'hFF, 8'h00, 0, 639, 235, 0, 19, 3);
      send_pkt(8'h08, 8'hFF, 8'h00, 0, 639, 235, 0, 19, 3);
      send_pkt(8'h09, 8'h00, 8'h00, 1, 639, 235, 0, 19, 3);
      send_pkt(8'h09, 8'h00, 8'h00, 0, 639, 235, 0, 19, 3);
      send_pkt(8'h08, 8'h00, 8'h00, 0, 639, 235, 0, 19, 3);
      send_pkt(8'h09, 8'h00, 8'h00, 1, 639, 235, 0, 19, 3);
      send_pkt(8'h0A, 8'h00, 8'h00, 0, 639, 235, 1, 19, 3);
      send_pkt(8'h08, 8'h00, 8'h00, 0, 639, 235, 0, 19, 3);
      send_pkt(8'h18, 8'h00, 8'h00, 0, 383, 235, 0, 11, 3);
      send_byte(8'h00);
      send_pkt(8'h08, 8'h01, 8'h01, 0, 384, 234, 0, 12, 3);
      send_byte(8'h08);
      send_byte(8'h05);
      repeat (TO + 5) @(posedge clk);
      send_pkt(8'h08, 8'h01, 8'h01, 0, 385, 233, 0, 12, 3);
      send_pkt(8'h48, 8'h10, 8'h10, 0, 385, 217, 0, 12, 3);
      send_pkt(8'h18, 8'h00, 8'h00, 0, 129, 217, 0, 4, 3);
      send_pkt(8'h18, 8'hE3, 8'h57, 0, 100, 130, 0, 3, 2);
      @(posedge clk); #1;
      interboard_rst = 1'b1;
      rxi.rx_data = 8'h08;
      rxi.rx_valid = 1'b1;
      @(posedge clk); #1;
      interboard_rst = 1'b0;
      rxi.rx_valid = 1'b0;
      @(negedge clk);
      chk("ib_x", int'(mouse_x), 320);
      chk("ib_y", int'(mouse_y), 240);
      @(negedge clk);
      chk("ib_bx", int'(mouse_block_x), 10);
      chk("ib_by", int'(mouse_block_y), 4);
      send_pkt(8'h08, 8'h01, 8'h01, 0, 321, 239, 0, 10, 3);
      send_pkt(8'h08, 8'h00, 8'hFF, 0, 321, 0, 0, 10, 0);
      send_pkt(8'h28, 8'h00, 8'h00, 0, 321, 256, 0, 10, 4);
      send_pkt(8'h28, 8'h00, 8'h00, 0, 321, 479, 0, 10, 7);
      send_pkt(8'h18, 8'h00, 8'h00, 0, 65, 479, 0, 2, 7);
      send_pkt(8'h18, 8'h00, 8'h00, 0, 0, 479, 0, 0, 7);
      budget = 50;
      while (q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      repeat (5) @(posedge clk);
      chk("pending", q.size(), 0);
      chk("packets_seen", seen, pushed);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mouse_packet_decoder.md
Name: mouse_packet_decoder

Overview:
Sits between the PS/2 byte receiver and the mouse interface top-level outputs. It assembles 3-byte PS/2 stream-mode packets and keeps an absolute cursor position clamped to the 640x480 screen. It also maps the cursor onto the board grid and produces click pulses. It produces mouse_valid, l_click, cheat_activate, mouse_x/y and mouse_block_x/y.

Parameters:
SCREEN_W, 640, horizontal pixel count; mouse_x range 0..SCREEN_W-1
SCREEN_H, 480, vertical pixel count; mouse_y range 0..SCREEN_H-1
BOARD_X0, 0, left pixel of board grid
BOARD_Y0, 0, top pixel of board grid
BLOCK_W, 32, block width in pixels
BLOCK_H, 60, block height in pixels
COLS, 20, number of block columns (<=32)
ROWS, 8, number of block rows (<=8)
TIMEOUT_CYC, 2000000, max clk cycles between bytes of one packet before resync

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
interboard_rst  in  1  synchronous re-centre request, active-high, from the other board
rx_data  in  8  received PS/2 byte
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
packet_done  out  1  one-cycle pulse when a packet is applied
mouse_x  out  10  cursor x
mouse_y  out  9  cursor y
l_click  out  1  one-cycle pulse on left-button press
cheat_activate  out  1  level; right button currently held
mouse_valid  out  1  cursor inside board grid
mouse_block_x  out  5  column index; 0 when !mouse_valid
mouse_block_y  out  3  row index; 0 when !mouse_valid

Behaviour:
- Reset (rst, async) values:
  - mouse_x=SCREEN_W/2 (320), mouse_y=SCREEN_H/2 (240).
  - packet_done=0, l_click=0, cheat_activate=0.
  - Internal button history cleared, FSM=B0, timeout counter=0.
  - Block outputs follow the reset position.
- interboard_rst, sampled on a clk edge, applies the same values synchronously. It has priority over rx_valid in the same cycle.
- FSM states:
  - B0: wait for byte0. On rx_valid, byte0 is accepted only if bit3=1, then latch it and go to B1. If bit3=0, discard the byte and stay in B0 (resync).
  - B1: on rx_valid, latch dx and go to B2.
  - B2: on rx_valid, latch dy and go to UPD.
  - UPD: one cycle. Apply the packet, pulse packet_done, return to B0. A rx_valid arriving in UPD is dropped; the receiver's byte spacing guarantees this does not occur in practice.
- Timeout counter:
  - Runs in B1/B2 and clears on each accepted byte.
  - Reaching TIMEOUT_CYC-1 returns the FSM to B0 and discards the partial packet. No output changes.
- byte0 fields: bit0=L, bit1=R, bit4=X sign, bit5=Y sign, bit6=X overflow, bit7=Y overflow.
- Deltas are 9-bit two's complement {sign, byte}, range -256..255.
- Position update in UPD:
  - New x = mouse_x + dx; new y = mouse_y - dy (PS/2 +y is up).
  - Compute in 12-bit signed arithmetic.
  - Clamp to 0 and to SCREEN_W-1 / SCREEN_H-1.
  - If an axis' overflow bit is set, that axis' delta is treated as 0. Buttons are still applied.
- Buttons in UPD:
  - l_click=1 for exactly the UPD cycle if L=1 and the previous packet's L=0.
  - cheat_activate <= R, held until the next packet.
- Grid mapping, registered one cycle after the position registers (total latency from the third rx_valid is 2 cycles):
  - mouse_valid=1 iff BOARD_X0 <= x < BOARD_X0+COLS*BLOCK_W and BOARD_Y0 <= y < BOARD_Y0+ROWS*BLOCK_H.
  - block_x=(x-BOARD_X0)/BLOCK_W and block_y=(y-BOARD_Y0)/BLOCK_H. These are constant-divisor divides and must meet timing at 100 MHz.
- A reset mid-packet abandons the packet; the next byte is evaluated as byte0.

Optional Feature:
MOUSE_ACCEL_EN
- Defined: per axis, if |delta| >= 16 (before the overflow check), the applied delta is doubled. Compute it in 12 bits, then clamp as above.
- Undefined: deltas are applied 1:1, with no extra logic.

Test Plan:
- Reset, then packet 0x08,0x0A,0x05 -> packet_done pulse; mouse_x=330, mouse_y=235; l_click stays 0.
- From 330,235, packet 0x18,0xF6,0x00 (dx=-10) -> mouse_x=320. Then packet 0x08,0xFF,0x00 repeated 3 times -> mouse_x=639 clamp, never wraps.
- Packets 0x09,0,0 then 0x09,0,0 then 0x08,0,0 then 0x09,0,0 -> l_click pulses exactly 1 cycle on packets 1 and 4 only. Packet 0x0A,0,0 -> cheat_activate=1; next 0x08,0,0 -> 0.
- Stray byte 0x00, then 0x08,0x01,0x01 -> 0x00 dropped; position moves +1/-1. Also send 0x08,0x05, then idle TIMEOUT_CYC cycles, then 0x08,0x01,0x01 -> only +1,-1 applied.
- Packet 0x48,0x10,0x10 (X overflow) -> x unchanged, y decreases by 16.
- Cursor at x=100,y=130 (defaults) -> mouse_valid=1, block_x=3, block_y=2. Assert interboard_rst -> x=320, y=240, block_x=10, block_y=4.
